// File: rtl/ula_multicycle_control.sv
// ula_multicycle_control
// ----------------------
// Multicycle MIPS control unit. It steps each instruction through fetch,
// decode, execute, memory and writeback states, drives the datapath selects
// and write enables, and turns Op/Funct into the 4-bit ALU operation code.
//
// Optional feature (compile-time macro ULA_CTRL_ILLEGAL_TRAP_EN):
//   defined   - an unknown Op (in DECODE) or Funct (in EXECUTE) parks the
//               unit in HALT with all outputs 0 and the sticky Illegal flag
//               set; only reset leaves HALT.
//   undefined - an unknown Op/Funct returns to FETCH without any write
//               (a NOP). There is no HALT state and no Illegal port.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset (forces INIT, outputs 0)
//   Op         in   [5:0] opcode, stable from the cycle after FETCH
//   Funct      in   [5:0] R-type function field
//   Zero       in   ALU zero flag, only used in BRANCH
//   ALUControl out  [3:0] ALU code (AND 0000, OR 0011, ADD 0010, SUB 0110, SLT 0111)
//   ALUSrcA    out  0=PC, 1=register A
//   ALUSrcB    out  [1:0] 00=reg B, 01=4, 10=sign-ext imm, 11=imm<<2
//   IorD       out  memory address: 0=PC, 1=ALUOut
//   IRWrite    out  instruction register load
//   MemWrite   out  data memory write
//   RegWrite   out  register file write
//   RegDst     out  0=rt, 1=rd
//   MemtoReg   out  0=ALUOut, 1=memory data
//   PCSrc      out  [1:0] 00=ALU result, 01=ALUOut, 10=jump target
//   PCEn       out  PC load enable = PCWrite | (Branch & Zero)
//   Illegal    out  sticky illegal-instruction flag (macro builds only)
//   dbg_state  out  [3:0] current state, for observation only
//
// Handshake: none. The unit free-runs one state per clock; the datapath is
// expected to honour every enable in the cycle it is asserted.

module ula_multicycle_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
   output logic [3:0] ALUControl,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       IorD,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic [1:0] PCSrc,
   output logic       PCEn,
`ifdef ULA_CTRL_ILLEGAL_TRAP_EN
   output logic       Illegal,
`endif
   output logic [3:0] dbg_state
);

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_RTYP = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   typedef enum logic [3:0] {
      S_INIT    = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_MEMADR  = 4'd3,
      S_MEMRD   = 4'd4,
      S_MEMWB   = 4'd5,
      S_MEMWR   = 4'd6,
      S_EXECUTE = 4'd7,
      S_ALUWB   = 4'd8,
      S_BRANCH  = 4'd9,
      S_ADDIEX  = 4'd10,
      S_ADDIWB  = 4'd11,
      S_JUMP    = 4'd12
`ifdef ULA_CTRL_ILLEGAL_TRAP_EN
      ,S_HALT   = 4'd13
`endif
   } state_t;

   // Where an unrecognised Op or Funct sends the machine.
`ifdef ULA_CTRL_ILLEGAL_TRAP_EN
   localparam state_t S_BAD = S_HALT;
`else
   localparam state_t S_BAD = S_FETCH;
`endif

   state_t state;
   state_t nxt;
   logic   pcwrite;
   logic   branch;

   function automatic logic funct_valid(input logic [5:0] f);
      case (f)
         6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] funct_alu(input logic [5:0] f);
      case (f)
         6'b100000: return ALU_ADD;
         6'b100010: return ALU_SUB;
         6'b100100: return ALU_AND;
         6'b100101: return ALU_OR;
         6'b101010: return ALU_SLT;
         default:   return ALU_AND;
      endcase
   endfunction

   always_comb begin
      nxt = state;
      case (state)
         S_INIT:    nxt = S_FETCH;
         S_FETCH:   nxt = S_DECODE;
         S_DECODE: begin
            case (Op)
               OP_LW, OP_SW: nxt = S_MEMADR;
               OP_RTYP:      nxt = S_EXECUTE;
               OP_BEQ:       nxt = S_BRANCH;
               OP_ADDI:      nxt = S_ADDIEX;
               OP_J:         nxt = S_JUMP;
               default:      nxt = S_BAD;
            endcase
         end
         S_MEMADR:  nxt = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   nxt = S_MEMWB;
         S_MEMWB:   nxt = S_FETCH;
         S_MEMWR:   nxt = S_FETCH;
         S_EXECUTE: nxt = funct_valid(Funct) ? S_ALUWB : S_BAD;
         S_ALUWB:   nxt = S_FETCH;
         S_BRANCH:  nxt = S_FETCH;
         S_ADDIEX:  nxt = S_ADDIWB;
         S_ADDIWB:  nxt = S_FETCH;
         S_JUMP:    nxt = S_FETCH;
`ifdef ULA_CTRL_ILLEGAL_TRAP_EN
         S_HALT:    nxt = S_HALT;
`endif
         default:   nxt = S_INIT;
      endcase
   end

   // Outputs are registered from the state being entered, so each output
   // is the Moore decode of the state it is held alongside. Funct is already
   // stable when DECODE hands over to EXECUTE, so the ALU code for EXECUTE
   // can be latched on that edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_INIT;
         ALUControl <= ALU_AND;
         ALUSrcA    <= 1'b0;
         ALUSrcB    <= 2'b00;
         IorD       <= 1'b0;
         IRWrite    <= 1'b0;
         MemWrite   <= 1'b0;
         RegWrite   <= 1'b0;
         RegDst     <= 1'b0;
         MemtoReg   <= 1'b0;
         PCSrc      <= 2'b00;
         pcwrite    <= 1'b0;
         branch     <= 1'b0;
`ifdef ULA_CTRL_ILLEGAL_TRAP_EN
         Illegal    <= 1'b0;
`endif
      end else begin
         state      <= nxt;
         ALUControl <= ALU_AND;
         ALUSrcA    <= 1'b0;
         ALUSrcB    <= 2'b00;
         IorD       <= 1'b0;
         IRWrite    <= 1'b0;
         MemWrite   <= 1'b0;
         RegWrite   <= 1'b0;
         RegDst     <= 1'b0;
         MemtoReg   <= 1'b0;
         PCSrc      <= 2'b00;
         pcwrite    <= 1'b0;
         branch     <= 1'b0;
         case (nxt)
            S_FETCH: begin
               ALUSrcB    <= 2'b01;
               ALUControl <= ALU_ADD;
               IRWrite    <= 1'b1;
               pcwrite    <= 1'b1;
            end
            S_DECODE: begin
               ALUSrcB    <= 2'b11;
               ALUControl <= ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
               ALUSrcA    <= 1'b1;
               ALUSrcB    <= 2'b10;
               ALUControl <= ALU_ADD;
            end
            S_MEMRD: IorD <= 1'b1;
            S_MEMWB: begin
               MemtoReg <= 1'b1;
               RegWrite <= 1'b1;
            end
            S_MEMWR: begin
               IorD     <= 1'b1;
               MemWrite <= 1'b1;
            end
            S_EXECUTE: begin
               ALUSrcA    <= 1'b1;
               ALUControl <= funct_alu(Funct);
            end
            S_ALUWB: begin
               RegDst   <= 1'b1;
               RegWrite <= 1'b1;
            end
            S_BRANCH: begin
               ALUSrcA    <= 1'b1;
               ALUControl <= ALU_SUB;
               PCSrc      <= 2'b01;
               branch     <= 1'b1;
            end
            S_ADDIWB: RegWrite <= 1'b1;
            S_JUMP: begin
               PCSrc   <= 2'b10;
               pcwrite <= 1'b1;
            end
`ifdef ULA_CTRL_ILLEGAL_TRAP_EN
            S_HALT: Illegal <= 1'b1;
`endif
            default: ;
         endcase
      end
   end

   // Zero reaches PCEn combinationally so a taken branch loads the PC in the
   // same BRANCH cycle; branch is 0 elsewhere, so Zero is ignored there.
   assign PCEn      = pcwrite | (branch & Zero);
   assign dbg_state = state;

endmodule

// File: tb/tb_ula_multicycle_control.sv
// tb_ula_multicycle_control
// -------------------------
// Runs directed and random instruction streams through the control unit.
// Each instruction is expanded, from the per-state output table, into the
// list of control words it should produce cycle by cycle; those words are
// queued and compared with the DUT outputs every cycle.
// Queue entry layout: {illegal, pcen_follows_zero, control_word[15:0]}.

module tb_ula_multicycle_control;

   localparam logic [3:0] A_AND = 4'b0000;
   localparam logic [3:0] A_OR  = 4'b0011;
   localparam logic [3:0] A_ADD = 4'b0010;
   localparam logic [3:0] A_SUB = 4'b0110;
   localparam logic [3:0] A_SLT = 4'b0111;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] Op = 6'd0;
   logic [5:0] Funct = 6'd0;
   logic       Zero = 1'b0;
   logic [3:0] ALUControl;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic       IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg;
   logic [1:0] PCSrc;
   logic       PCEn;
`ifdef ULA_CTRL_ILLEGAL_TRAP_EN
   logic       Illegal;
`endif
   logic [3:0] dbg_state;

   logic [17:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   ula_multicycle_control dut (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
      .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .IorD(IorD), .IRWrite(IRWrite), .MemWrite(MemWrite),
      .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
      .PCSrc(PCSrc), .PCEn(PCEn),
`ifdef ULA_CTRL_ILLEGAL_TRAP_EN
      .Illegal(Illegal),
`endif
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s at %0t: got %h expected %h (Op=%b Funct=%b Zero=%b)",
                  tag, $time, got, exp, Op, Funct, Zero);
      else
         n_pass++;
   endtask

   function automatic logic [15:0] cw(input logic [3:0] alu, input logic srca,
                                      input logic [1:0] srcb, input logic iord,
                                      input logic irw, input logic memw,
                                      input logic regw, input logic regdst,
                                      input logic m2r, input logic [1:0] pcsrc,
                                      input logic pcen);
      return {alu, srca, srcb, iord, irw, memw, regw, regdst, m2r, pcsrc, pcen};
   endfunction

   function automatic logic [15:0] obs();
      return {ALUControl, ALUSrcA, ALUSrcB, IorD, IRWrite, MemWrite,
              RegWrite, RegDst, MemtoReg, PCSrc, PCEn};
   endfunction

   // {valid, alu code} for an R-type function field
   function automatic logic [4:0] funct_code(input logic [5:0] f);
      case (f)
         6'h20:   return {1'b1, A_ADD};
         6'h22:   return {1'b1, A_SUB};
         6'h24:   return {1'b1, A_AND};
         6'h25:   return {1'b1, A_OR};
         6'h2a:   return {1'b1, A_SLT};
         default: return {1'b0, A_AND};
      endcase
   endfunction

   function automatic logic op_known(input logic [5:0] op);
      return (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
             (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010);
   endfunction

   task automatic push_halt();
      for (int i = 0; i < 10; i++) exp_q.push_back({1'b1, 1'b0, 16'h0000});
   endtask

   // ---------------- reference model: instruction -> control words ----------------
   task automatic push_instr(input logic [5:0] op, input logic [5:0] f);
      logic [4:0] fc;
      fc = funct_code(f);
      exp_q.push_back({2'b00, cw(A_ADD, 0, 2'b01, 0, 1, 0, 0, 0, 0, 2'b00, 1)}); // fetch
      exp_q.push_back({2'b00, cw(A_ADD, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0)}); // decode
      case (op)
         6'b100011: begin
            exp_q.push_back({2'b00, cw(A_ADD, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0)});
            exp_q.push_back({2'b00, cw(A_AND, 0, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 0)});
            exp_q.push_back({2'b00, cw(A_AND, 0, 2'b00, 0, 0, 0, 1, 0, 1, 2'b00, 0)});
         end
         6'b101011: begin
            exp_q.push_back({2'b00, cw(A_ADD, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0)});
            exp_q.push_back({2'b00, cw(A_AND, 0, 2'b00, 1, 0, 1, 0, 0, 0, 2'b00, 0)});
         end
         6'b000000: begin
            exp_q.push_back({2'b00, cw(fc[3:0], 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0)});
            if (fc[4])
               exp_q.push_back({2'b00, cw(A_AND, 0, 2'b00, 0, 0, 0, 1, 1, 0, 2'b00, 0)});
`ifdef ULA_CTRL_ILLEGAL_TRAP_EN
            else
               push_halt();
`endif
         end
         6'b000100:
            exp_q.push_back({2'b01, cw(A_SUB, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 0)});
         6'b001000: begin
            exp_q.push_back({2'b00, cw(A_ADD, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0)});
            exp_q.push_back({2'b00, cw(A_AND, 0, 2'b00, 0, 0, 0, 1, 0, 0, 2'b00, 0)});
         end
         6'b000010:
            exp_q.push_back({2'b00, cw(A_AND, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 1)});
         default: begin
`ifdef ULA_CTRL_ILLEGAL_TRAP_EN
            push_halt();
`endif
         end
      endcase
   endtask

   // ---------------- driver tasks ----------------
   // One DUT cycle: check with a random Zero, then with Zero flipped, so the
   // combinational Zero->PCEn path is exercised (and must stay idle outside BRANCH).
   task automatic step();
      logic [17:0] e;
      logic [15:0] exp;
      logic        z;
      e = exp_q.pop_front();
      z = 1'($urandom_range(0, 1));
      for (int k = 0; k < 2; k++) begin
         Zero = z;
         #1;
         exp = e[15:0];
         if (e[16]) exp[0] = z;
         check("ctrl_word", 32'(obs()), 32'(exp));
`ifdef ULA_CTRL_ILLEGAL_TRAP_EN
         check("illegal_flag", 32'(Illegal), 32'(e[17]));
`endif
         z = ~z;
      end
      @(negedge clk);
   endtask

   // Called on a negedge; returns on the negedge inside the first FETCH.
   task automatic do_reset();
      exp_q.delete();
      reset = 1'b1;
      Zero  = 1'b1;
      #1;
      check("reset_outputs", 32'(obs()), 32'h0);
`ifdef ULA_CTRL_ILLEGAL_TRAP_EN
      check("reset_illegal", 32'(Illegal), 32'h0);
`endif
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("init_outputs", 32'(obs()), 32'h0);
      @(negedge clk);
   endtask

   task automatic run_instr(input logic [5:0] op, input logic [5:0] f);
      Op    = op;
      Funct = f;
      push_instr(op, f);
      while (exp_q.size() > 0) step();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [17:0] e;
      logic [5:0]  op, f;
      logic [5:0]  ops[7];
      logic [5:0]  fns[5];
      ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

      @(negedge clk);
      do_reset();

      // directed
      run_instr(6'b100011, 6'h00);   // lw
      run_instr(6'b000000, 6'h2a);   // slt
      run_instr(6'b000000, 6'h22);   // sub
      run_instr(6'b000100, 6'h00);   // beq
      run_instr(6'b000100, 6'h3f);   // beq
      run_instr(6'b001000, 6'h00);   // addi
      run_instr(6'b000010, 6'h00);   // j
      run_instr(6'b101011, 6'h00);   // sw

      // reset in the middle of a store, while MemWrite is high
      Op = 6'b101011;
      push_instr(Op, Funct);
      for (int i = 0; i < 3; i++) step();
      e = exp_q.pop_front();
      #1 check("memwr_before_reset", 32'(obs()), 32'(e[15:0]));
      do_reset();

      // random instruction stream
      for (int n = 0; n < 60; n++) begin
         op = ops[$urandom_range(0, 6)];
         f  = ($urandom_range(0, 1) == 1) ? fns[$urandom_range(0, 4)]
                                          : 6'($urandom_range(0, 63));
`ifdef ULA_CTRL_ILLEGAL_TRAP_EN
         if (!funct_code(f)[4]) f = 6'h20;
`else
         if ($urandom_range(0, 5) == 0) op = 6'($urandom_range(0, 63));
`endif
         if (op == 6'b000000 || op_known(op) || op != 6'b000000)
            run_instr(op, f);
      end

      // unknown Op / Funct
`ifdef ULA_CTRL_ILLEGAL_TRAP_EN
      run_instr(6'h3f, 6'h20);
      do_reset();
      run_instr(6'b000000, 6'h3f);
      do_reset();
`else
      run_instr(6'h3f, 6'h20);
      run_instr(6'b000000, 6'h3f);
`endif
      run_instr(6'b000000, 6'h25);   // or, back to normal

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
